// File: rtl/game_pkg.sv
// Shared game-logic definitions for the projectile fire scheduler.
//   FIRE_KEY      : keycode that means "fire"
//   sched_state_t : scheduler FSM encoding (also driven out for debug LEDs)
package game_pkg;

    localparam logic [7:0] FIRE_KEY = 8'h2C;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/projectile_fire_scheduler_rr_free_picker.sv
// rr_free_picker: combinational round-robin free-slot search.
// Scans slots rr_ptr, rr_ptr+1, ... (mod NUM_SLOTS) and returns the first
// slot whose busy bit is clear.
//   busy   in  NUM_SLOTS  per-slot busy flags
//   rr_ptr in  PW         slot to start the search at
//   found  out 1          a free slot exists
//   idx    out PW         first free slot at or after rr_ptr (0 when !found)
module rr_free_picker #(
    parameter int NUM_SLOTS = 4,
    parameter int PW        = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [PW-1:0]        rr_ptr,
    output logic                 found,
    output logic [PW-1:0]        idx
);

    logic [PW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_SLOTS);
            if (!found && !busy[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/projectile_fire_scheduler.sv
// projectile_fire_scheduler: routes the player's fire key onto a pool of
// projectile instances. A free slot is granted round-robin, its shoot line
// is held until the slot reports in flight (ack), then a frame-counted
// cooldown blocks further grants.
// Build option: define PROJ_AUTOFIRE_EN to let a held fire key re-fire each
// time the cooldown expires; otherwise every press yields one grant/denial.
//   Clk          in   system clock
//   Reset        in   synchronous, active-high
//   frame_clk    in   asynchronous frame clock, rising edge detected here
//   keycode      in   current key code
//   slot_busy    in   is_showing of each projectile instance
//   shoot        out  one-hot launch request to the granted slot
//   sched_state  out  FSM state
//   shots_fired  out  acknowledged launches (wrapping)
//   shots_denied out  presses finding no free slot (saturating)
module projectile_fire_scheduler
    import game_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [7:0]           keycode,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] shoot,
    output logic [1:0]           sched_state,
    output logic [15:0]          shots_fired,
    output logic [7:0]           shots_denied
);

    localparam int PW = $clog2(NUM_SLOTS);

    sched_state_t          state;
    logic [2:0]            fsync;      // [1:0] synchronizer, [2] delayed copy
    logic                  frame_tick;
    logic                  fire_key;
    logic                  fire_armed;
    logic                  fire_req;
    logic [NUM_SLOTS-1:0]  busy_q;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         g_idx;
    logic [7:0]            cooldown;
    logic [2:0]            wait_cnt;
    logic                  found;
    logic [PW-1:0]         pick_idx;
    logic                  ack;

    assign frame_tick  = fsync[1] & ~fsync[2];
    assign fire_key    = (keycode == FIRE_KEY);
    assign fire_req    = frame_tick & fire_key & fire_armed;
    // Only the granted slot's 0->1 transition counts; other slots are ignored.
    assign ack         = (state == GRANT) && slot_busy[g_idx] && !busy_q[g_idx];
    assign sched_state = state;

    rr_free_picker #(.NUM_SLOTS(NUM_SLOTS), .PW(PW)) u_picker (
        .busy   (slot_busy),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync        <= '0;
            busy_q       <= '0;
            state        <= IDLE;
            shoot        <= '0;
            rr_ptr       <= '0;
            g_idx        <= '0;
            cooldown     <= '0;
            wait_cnt     <= '0;
            shots_fired  <= '0;
            shots_denied <= '0;
            fire_armed   <= 1'b1;
        end else begin
            fsync  <= {fsync[1:0], frame_clk};
            busy_q <= slot_busy;

`ifdef PROJ_AUTOFIRE_EN
            fire_armed <= 1'b1;
`else
            // Re-arm once the key is seen released at a tick; disarm when a
            // press is consumed (granted or denied) in IDLE.
            if (frame_tick && !fire_key)
                fire_armed <= 1'b1;
            else if (fire_req && state == IDLE)
                fire_armed <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    shoot <= '0;
                    if (fire_req) begin
                        if (found) begin
                            shoot    <= NUM_SLOTS'(1) << pick_idx;
                            g_idx    <= pick_idx;
                            rr_ptr   <= (pick_idx == PW'(NUM_SLOTS - 1)) ? '0 : pick_idx + PW'(1);
                            wait_cnt <= '0;
                            state    <= GRANT;
                        end else if (shots_denied != 8'hFF) begin
                            shots_denied <= shots_denied + 8'd1;
                        end
                    end
                end
                GRANT: begin
                    // Ack wins over a coincident frame tick.
                    if (ack) begin
                        shoot       <= '0;
                        shots_fired <= shots_fired + 16'd1;
                        cooldown    <= 8'(COOLDOWN_FRAMES);
                        state       <= COOLDOWN;
                    end else if (frame_tick) begin
                        if (wait_cnt == 3'(ACK_TIMEOUT - 1)) begin
                            shoot <= '0;
                            state <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    shoot <= '0;
                    if (frame_tick) begin
                        if (cooldown <= 8'd1) begin
                            cooldown <= '0;
                            state    <= IDLE;
                        end else begin
                            cooldown <= cooldown - 8'd1;
                        end
                    end
                end
                default: begin
                    shoot <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_projectile_fire_scheduler.sv
// Directed bench for projectile_fire_scheduler (default parameters:
// 4 slots, 8 cooldown frames, ack timeout 3 frames).
module tb_projectile_fire_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic [3:0]  slot_busy;
    logic [3:0]  shoot;
    logic [1:0]  sched_state;
    logic [15:0] shots_fired;
    logic [7:0]  shots_denied;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] KEY = 8'h2C;

    projectile_fire_scheduler dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .slot_busy    (slot_busy),
        .shoot        (shoot),
        .sched_state  (sched_state),
        .shots_fired  (shots_fired),
        .shots_denied (shots_denied)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; slot_busy = 4'b0000;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    // One full frame_clk period; its rising edge is fully processed on return.
    task automatic do_frame();
        @(negedge Clk); frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    // Raise the granted slot's busy bit for one cycle (projectile launched).
    task automatic ack_slot(input logic [3:0] base, input logic [3:0] bit_one_hot);
        slot_busy = base | bit_one_hot;
        @(negedge Clk);
        slot_busy = base;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (shoot !== 4'b0000) begin n_fail++; $display("FAIL reset_shoot: got %b want 0000", shoot); end
        n_checks++; if (sched_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", sched_state); end
        n_checks++; if (shots_fired !== 16'd0 || shots_denied !== 8'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", shots_fired, shots_denied); end
    endtask

    task automatic test_basic_launch();
        do_reset();
        keycode = KEY;
        do_frame();
        n_checks++; if (shoot !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b want 0001", shoot); end
        n_checks++; if (sched_state !== 2'd1) begin n_fail++; $display("FAIL basic_grant_state: got %0d want 1", sched_state); end
        slot_busy = 4'b0001;
        @(negedge Clk);
        n_checks++; if (shoot !== 4'b0000) begin n_fail++; $display("FAIL basic_ack_shoot: got %b want 0000", shoot); end
        n_checks++; if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL basic_ack_fired: got %0d want 1", shots_fired); end
        n_checks++; if (sched_state !== 2'd2) begin n_fail++; $display("FAIL basic_ack_state: got %0d want 2", sched_state); end
        keycode = 8'h00;
        repeat (7) do_frame();
        n_checks++; if (sched_state !== 2'd2) begin n_fail++; $display("FAIL cooldown_7: got %0d want 2", sched_state); end
        do_frame();
        n_checks++; if (sched_state !== 2'd0) begin n_fail++; $display("FAIL cooldown_8: got %0d want 0", sched_state); end
    endtask

`ifndef PROJ_AUTOFIRE_EN
    task automatic test_edge_mode();
        do_reset();
        keycode = KEY;
        do_frame();
        ack_slot(4'b0001, 4'b0001);
        repeat (40) do_frame();
        n_checks++; if (shots_fired !== 16'd1) begin n_fail++; $display("FAIL edge_hold_fired: got %0d want 1", shots_fired); end
        n_checks++; if (shoot !== 4'b0000 || sched_state !== 2'd0) begin n_fail++; $display("FAIL edge_hold_idle: got %b/%0d want 0000/0", shoot, sched_state); end
        keycode = 8'h00; do_frame();
        keycode = KEY;   do_frame();
        n_checks++; if (shoot !== 4'b0010) begin n_fail++; $display("FAIL edge_second_grant: got %b want 0010", shoot); end
        ack_slot(4'b0001, 4'b0010);
        n_checks++; if (shots_fired !== 16'd2) begin n_fail++; $display("FAIL edge_second_fired: got %0d want 2", shots_fired); end
    endtask
`else
    task automatic test_autofire();
        do_reset();
        keycode = KEY;
        for (int f = 0; f < 30; f++) begin
            do_frame();
            if (shoot != 4'b0000) ack_slot(4'b0000, shoot);
        end
        // grants at frames 1, 10, 19, 28
        n_checks++; if (shots_fired !== 16'd4) begin n_fail++; $display("FAIL autofire_count: got %0d want 4", shots_fired); end
    endtask
`endif

    task automatic test_denied();
        do_reset();
        slot_busy = 4'b1111;
        keycode = KEY; do_frame();
        n_checks++; if (shoot !== 4'b0000 || sched_state !== 2'd0) begin n_fail++; $display("FAIL denied_noshoot: got %b/%0d want 0000/0", shoot, sched_state); end
        n_checks++; if (shots_denied !== 8'd1) begin n_fail++; $display("FAIL denied_one: got %0d want 1", shots_denied); end
        for (int p = 1; p < 254; p++) begin
            keycode = 8'h00; do_frame();
            keycode = KEY;   do_frame();
        end
        n_checks++; if (shots_denied !== 8'd254) begin n_fail++; $display("FAIL denied_254: got %0d want 254", shots_denied); end
        for (int p = 254; p < 300; p++) begin
            keycode = 8'h00; do_frame();
            keycode = KEY;   do_frame();
        end
        n_checks++; if (shots_denied !== 8'd255) begin n_fail++; $display("FAIL denied_saturate: got %0d want 255", shots_denied); end
        n_checks++; if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL denied_fired: got %0d want 0", shots_fired); end
    endtask

    task automatic test_ack_timeout();
        do_reset();
        keycode = KEY; do_frame();
        keycode = 8'h00;
        n_checks++; if (shoot !== 4'b0001) begin n_fail++; $display("FAIL timeout_grant: got %b want 0001", shoot); end
        do_frame(); do_frame();
        n_checks++; if (shoot !== 4'b0001 || sched_state !== 2'd1) begin n_fail++; $display("FAIL timeout_held: got %b/%0d want 0001/1", shoot, sched_state); end
        do_frame();
        n_checks++; if (shoot !== 4'b0000 || sched_state !== 2'd0) begin n_fail++; $display("FAIL timeout_drop: got %b/%0d want 0000/0", shoot, sched_state); end
        n_checks++; if (shots_fired !== 16'd0) begin n_fail++; $display("FAIL timeout_fired: got %0d want 0", shots_fired); end
        keycode = KEY; do_frame();
        n_checks++; if (shoot !== 4'b0010) begin n_fail++; $display("FAIL timeout_rr_kept: got %b want 0010", shoot); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010;
        do_reset();
        slot_busy = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            keycode = KEY; do_frame();
            n_checks++; if (shoot !== exp_seq[k]) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, shoot, exp_seq[k]); end
            ack_slot(4'b0101, exp_seq[k]);
            keycode = 8'h00;
            repeat (8) do_frame();
        end
        n_checks++; if (shots_fired !== 16'd3) begin n_fail++; $display("FAIL rr_fired: got %0d want 3", shots_fired); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        keycode = KEY; do_frame();
        n_checks++; if (shoot !== 4'b0001) begin n_fail++; $display("FAIL midreset_grant: got %b want 0001", shoot); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        n_checks++; if (shoot !== 4'b0000 || sched_state !== 2'd0) begin n_fail++; $display("FAIL midreset_drop: got %b/%0d want 0000/0", shoot, sched_state); end
        slot_busy = 4'b0001;
        @(negedge Clk);
        n_checks++; if (shots_fired !== 16'd0 || shots_denied !== 8'd0) begin n_fail++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", shots_fired, shots_denied); end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; slot_busy = 4'b0000;
        test_reset();
        test_basic_launch();
`ifndef PROJ_AUTOFIRE_EN
        test_edge_mode();
`else
        test_autofire();
`endif
        test_denied();
        test_ack_timeout();
        test_round_robin();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
